// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: walks every input vector, holds it DWELL clocks,
// captures the DUT output per vector. Optional compare logic under SWEEPER_COMPARE_EN.
module truth_table_sweeper #(
    parameter int N_IN  = 4,
    parameter int DWELL = 1,
    parameter logic [(1<<N_IN)-1:0] EXPECTED = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  dut_y,
    output logic [N_IN-1:0]       vec_out,
    output logic                  busy,
    output logic                  done,
    output logic [(1<<N_IN)-1:0]  table_out,
    output logic [N_IN:0]         ones_count
`ifdef SWEEPER_COMPARE_EN
    ,
    output logic                  fail,
    output logic                  pass,
    output logic [N_IN-1:0]       fail_idx
`endif
);

    localparam int TBL_W = $bits(EXPECTED);
    localparam logic [7:0] DW_LAST = 8'(DWELL - 1);
    localparam logic [N_IN-1:0] VEC_LAST = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [N_IN-1:0]    r_vec;
    logic [7:0]         r_dwell;
    logic               r_busy;
    logic               r_done;
    logic [TBL_W-1:0]   r_table;
    logic [N_IN:0]      r_ones;

    logic               w_last_dwell;
    logic               w_last_vec;
    logic [N_IN:0]      w_y_ext;

    assign w_last_dwell = (r_dwell == DW_LAST);
    assign w_last_vec   = (r_vec == VEC_LAST);
    assign w_y_ext      = (N_IN+1)'(dut_y);

`ifdef SWEEPER_COMPARE_EN
    logic               r_fail;
    logic               r_pass;
    logic [N_IN-1:0]    r_fail_idx;
    logic               w_mismatch;

    assign w_mismatch = (dut_y != EXPECTED[r_vec]);
`endif

    // Sweep sequencer: state, vector stepping, capture and ones counting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_vec   <= '0;
            r_dwell <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_table <= '0;
            r_ones  <= '0;
`ifdef SWEEPER_COMPARE_EN
            r_fail     <= 1'b0;
            r_pass     <= 1'b0;
            r_fail_idx <= '0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef SWEEPER_COMPARE_EN
            r_pass <= 1'b0;
`endif
            case (r_state)
                S_APPLY: begin
                    if (abort) begin
                        // partial table and count are kept for inspection
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_vec   <= '0;
                        r_dwell <= '0;
                    end else if (w_last_dwell) begin
                        r_dwell        <= '0;
                        r_table[r_vec] <= dut_y;
                        r_ones         <= r_ones + w_y_ext;
`ifdef SWEEPER_COMPARE_EN
                        if (w_mismatch && !r_fail) begin
                            r_fail     <= 1'b1;
                            r_fail_idx <= r_vec;
                        end
`endif
                        if (w_last_vec) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_vec   <= '0;
`ifdef SWEEPER_COMPARE_EN
                            r_pass  <= !(r_fail || w_mismatch);
`endif
                        end else begin
                            r_vec <= r_vec + N_IN'(1);
                        end
                    end else begin
                        r_dwell <= r_dwell + 8'd1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept start; start beats abort here
                    if (start) begin
                        r_state <= S_APPLY;
                        r_busy  <= 1'b1;
                        r_vec   <= '0;
                        r_dwell <= '0;
                        r_table <= '0;
                        r_ones  <= '0;
`ifdef SWEEPER_COMPARE_EN
                        r_fail     <= 1'b0;
                        r_fail_idx <= '0;
`endif
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign vec_out    = r_vec;
    assign busy       = r_busy;
    assign done       = r_done;
    assign table_out  = r_table;
    assign ones_count = r_ones;
`ifdef SWEEPER_COMPARE_EN
    assign fail       = r_fail;
    assign pass       = r_pass;
    assign fail_idx   = r_fail_idx;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (DWELL=1 and DWELL=3) each driven
// by a table-lookup DUT; expectations come from the function table itself.
module tb_truth_table_sweeper;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        startA = 1'b0, abortA = 1'b0;
    logic [15:0] tblA = '0;
    logic        yA;
    logic [3:0]  vecA;
    logic        busyA, doneA;
    logic [15:0] tabA;
    logic [4:0]  onesA;

    logic        startB = 1'b0, abortB = 1'b0;
    logic [15:0] tblB = '0;
    logic        yB;
    logic [3:0]  vecB;
    logic        busyB, doneB;
    logic [15:0] tabB;
    logic [4:0]  onesB;

`ifdef SWEEPER_COMPARE_EN
    logic        failA, passA, failB, passB;
    logic [3:0]  idxA, idxB;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign yA = tblA[vecA];
    assign yB = tblB[vecB];

    truth_table_sweeper #(.N_IN(4), .DWELL(1), .EXPECTED(16'h6996)) u_a (
        .clk(clk), .rst(rst), .start(startA), .abort(abortA), .dut_y(yA),
        .vec_out(vecA), .busy(busyA), .done(doneA),
        .table_out(tabA), .ones_count(onesA)
`ifdef SWEEPER_COMPARE_EN
        , .fail(failA), .pass(passA), .fail_idx(idxA)
`endif
    );

    truth_table_sweeper #(.N_IN(4), .DWELL(3), .EXPECTED(16'h8000)) u_b (
        .clk(clk), .rst(rst), .start(startB), .abort(abortB), .dut_y(yB),
        .vec_out(vecB), .busy(busyB), .done(doneB),
        .table_out(tabB), .ones_count(onesB)
`ifdef SWEEPER_COMPARE_EN
        , .fail(failB), .pass(passB), .fail_idx(idxB)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        tests++;
        if ({vecA, busyA, doneA, tabA, onesA} !== 27'd0) begin
            fails++;
            $display("FAIL reset_a got %h required 0", {vecA, busyA, doneA, tabA, onesA});
        end
        tests++;
        if ({vecB, busyB, doneB, tabB, onesB} !== 27'd0) begin
            fails++;
            $display("FAIL reset_b got %h required 0", {vecB, busyB, doneB, tabB, onesB});
        end
`ifdef SWEEPER_COMPARE_EN
        tests++;
        if ({failA, passA, idxA} !== 6'd0) begin
            fails++;
            $display("FAIL reset_cmp got %h required 0", {failA, passA, idxA});
        end
`endif
        rst = 1'b0;
        step();
    endtask

    task automatic test_xor();
        tblA = 16'h6996;
        startA = 1'b1;
        step();
        startA = 1'b0;
        tests++;
        if (busyA !== 1'b1 || vecA !== 4'd0) begin
            fails++;
            $display("FAIL xor_start busy=%b vec=%0d required busy=1 vec=0", busyA, vecA);
        end
        for (int k = 1; k < 16; k++) begin
            step();
            tests++;
            if (vecA !== 4'(k) || busyA !== 1'b1 || doneA !== 1'b0) begin
                fails++;
                $display("FAIL xor_step vec=%0d busy=%b done=%b required vec=%0d busy=1 done=0",
                         vecA, busyA, doneA, k);
            end
        end
        step();
        tests++;
        if (doneA !== 1'b1 || busyA !== 1'b0 || vecA !== 4'd0) begin
            fails++;
            $display("FAIL xor_done done=%b busy=%b vec=%0d required 1 0 0", doneA, busyA, vecA);
        end
        tests++;
        if (tabA !== 16'h6996) begin
            fails++;
            $display("FAIL xor_table got %h required 6996", tabA);
        end
        tests++;
        if (onesA !== 5'd8) begin
            fails++;
            $display("FAIL xor_ones got %0d required 8", onesA);
        end
        step();
        tests++;
        if (doneA !== 1'b0 || tabA !== 16'h6996 || onesA !== 5'd8) begin
            fails++;
            $display("FAIL xor_hold done=%b table=%h ones=%0d required 0 6996 8", doneA, tabA, onesA);
        end
    endtask

    task automatic test_random_sweeps();
        logic [15:0] f;
        int n;
        for (int r = 0; r < 4; r++) begin
            f = 16'($urandom);
            tblA = f;
            startA = 1'b1;
            step();
            startA = 1'b0;
            n = 0;
            while (doneA !== 1'b1 && n < 40) begin
                step();
                n++;
            end
            tests++;
            if (n !== 16) begin
                fails++;
                $display("FAIL rand_latency got %0d required 16", n);
            end
            tests++;
            if (tabA !== f || onesA !== 5'($countones(f))) begin
                fails++;
                $display("FAIL rand_table got %h/%0d required %h/%0d", tabA, onesA, f, $countones(f));
            end
            step();
        end
    endtask

    task automatic test_dwell3();
        tblB = 16'h8000;
        startB = 1'b1;
        step();
        startB = 1'b0;
        for (int e = 1; e < 48; e++) begin
            step();
            tests++;
            if (vecB !== 4'(e / 3) || busyB !== 1'b1 || doneB !== 1'b0) begin
                fails++;
                $display("FAIL dwell3_step edge=%0d vec=%0d busy=%b done=%b required vec=%0d",
                         e, vecB, busyB, doneB, e / 3);
            end
            if (e == 21) startB = 1'b1;
            if (e == 22) startB = 1'b0;
        end
        step();
        tests++;
        if (doneB !== 1'b1 || busyB !== 1'b0) begin
            fails++;
            $display("FAIL dwell3_done done=%b busy=%b required 1 0", doneB, busyB);
        end
        tests++;
        if (tabB !== 16'h8000 || onesB !== 5'd1) begin
            fails++;
            $display("FAIL dwell3_table got %h/%0d required 8000/1", tabB, onesB);
        end
        step();
    endtask

    task automatic test_abort();
        logic [15:0] f;
        logic [15:0] exp_t;
        int p;
        int seen;
        tblA = 16'h6996;
        startA = 1'b1;
        step();
        startA = 1'b0;
        for (int k = 0; k < 5; k++) step();
        tests++;
        if (vecA !== 4'd5) begin
            fails++;
            $display("FAIL abort_pre vec=%0d required 5", vecA);
        end
        abortA = 1'b1;
        step();
        abortA = 1'b0;
        tests++;
        if (busyA !== 1'b0 || vecA !== 4'd0 || doneA !== 1'b0) begin
            fails++;
            $display("FAIL abort_state busy=%b vec=%0d done=%b required 0 0 0", busyA, vecA, doneA);
        end
        tests++;
        if (tabA !== 16'h0016 || onesA !== 5'd3) begin
            fails++;
            $display("FAIL abort_table got %h/%0d required 0016/3", tabA, onesA);
        end
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (doneA === 1'b1 || busyA === 1'b1) seen++;
        end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL abort_idle active_cycles=%0d required 0", seen);
        end
        f = 16'($urandom);
        p = $urandom_range(1, 15);
        tblA = f;
        startA = 1'b1;
        abortA = 1'b1;
        step();
        startA = 1'b0;
        abortA = 1'b0;
        tests++;
        if (busyA !== 1'b1 || tabA !== 16'h0 || onesA !== 5'd0) begin
            fails++;
            $display("FAIL abort_startwins busy=%b table=%h ones=%0d required 1 0 0", busyA, tabA, onesA);
        end
        for (int k = 0; k < p; k++) step();
        abortA = 1'b1;
        step();
        abortA = 1'b0;
        exp_t = f & 16'((32'd1 << p) - 1);
        tests++;
        if (tabA !== exp_t || onesA !== 5'($countones(exp_t)) || busyA !== 1'b0) begin
            fails++;
            $display("FAIL abort_rand p=%0d got %h/%0d required %h/%0d",
                     p, tabA, onesA, exp_t, $countones(exp_t));
        end
        step();
    endtask

    task automatic test_async_reset();
        tblA = 16'h6996;
        startA = 1'b1;
        step();
        startA = 1'b0;
        for (int k = 0; k < 6; k++) step();
        #3;
        rst = 1'b1;
        #1;
        tests++;
        if ({vecA, busyA, doneA, tabA, onesA} !== 27'd0) begin
            fails++;
            $display("FAIL async_rst got %h required 0", {vecA, busyA, doneA, tabA, onesA});
        end
        #2;
        rst = 1'b0;
        step();
        tests++;
        if (busyA !== 1'b0) begin
            fails++;
            $display("FAIL async_rst_idle busy=%b required 0", busyA);
        end
        startA = 1'b1;
        step();
        startA = 1'b0;
        for (int k = 0; k < 16; k++) step();
        tests++;
        if (doneA !== 1'b1 || tabA !== 16'h6996 || onesA !== 5'd8) begin
            fails++;
            $display("FAIL async_rst_sweep done=%b table=%h ones=%0d required 1 6996 8", doneA, tabA, onesA);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [15:0] f1, f2;
        f1 = 16'($urandom);
        f2 = ~f1;
        tblA = f1;
        startA = 1'b1;
        step();
        for (int k = 0; k < 16; k++) step();
        tests++;
        if (doneA !== 1'b1 || tabA !== f1) begin
            fails++;
            $display("FAIL b2b_first done=%b table=%h required 1 %h", doneA, tabA, f1);
        end
        tblA = f2;
        step();
        startA = 1'b0;
        tests++;
        if (busyA !== 1'b1 || doneA !== 1'b0 || tabA !== 16'h0 || onesA !== 5'd0 || vecA !== 4'd0) begin
            fails++;
            $display("FAIL b2b_restart busy=%b done=%b table=%h ones=%0d vec=%0d required 1 0 0 0 0",
                     busyA, doneA, tabA, onesA, vecA);
        end
        for (int k = 0; k < 16; k++) step();
        tests++;
        if (doneA !== 1'b1 || tabA !== f2 || onesA !== 5'($countones(f2))) begin
            fails++;
            $display("FAIL b2b_second done=%b table=%h ones=%0d required 1 %h %0d",
                     doneA, tabA, onesA, f2, $countones(f2));
        end
        step();
    endtask

`ifdef SWEEPER_COMPARE_EN
    task automatic test_compare();
        int j;
        tblA = 16'h0;
        startA = 1'b1;
        step();
        startA = 1'b0;
        step();
        step();
        tests++;
        if (failA !== 1'b1 || idxA !== 4'd1) begin
            fails++;
            $display("FAIL cmp_early fail=%b idx=%0d required 1 1", failA, idxA);
        end
        for (int k = 0; k < 14; k++) step();
        tests++;
        if (doneA !== 1'b1 || failA !== 1'b1 || idxA !== 4'd1 || passA !== 1'b0) begin
            fails++;
            $display("FAIL cmp_stuck done=%b fail=%b idx=%0d pass=%b required 1 1 1 0",
                     doneA, failA, idxA, passA);
        end
        step();
        tblA = 16'h6996;
        startA = 1'b1;
        step();
        startA = 1'b0;
        for (int k = 0; k < 16; k++) step();
        tests++;
        if (doneA !== 1'b1 || passA !== 1'b1 || failA !== 1'b0) begin
            fails++;
            $display("FAIL cmp_pass done=%b pass=%b fail=%b required 1 1 0", doneA, passA, failA);
        end
        step();
        tests++;
        if (passA !== 1'b0) begin
            fails++;
            $display("FAIL cmp_pass_pulse pass=%b required 0", passA);
        end
        j = $urandom_range(0, 15);
        tblA = 16'h6996 ^ 16'(32'd1 << j);
        startA = 1'b1;
        step();
        startA = 1'b0;
        for (int k = 0; k < 16; k++) step();
        tests++;
        if (failA !== 1'b1 || idxA !== 4'(j) || passA !== 1'b0) begin
            fails++;
            $display("FAIL cmp_flip fail=%b idx=%0d pass=%b required 1 %0d 0", failA, idxA, passA, j);
        end
        step();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_xor();
        test_random_sweeps();
        test_dwell3();
        test_abort();
        test_async_reset();
        test_back_to_back();
`ifdef SWEEPER_COMPARE_EN
        test_compare();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Parametrised, self-sequencing exhaustive tester for an N-input, single-output combinational function. Drives every input vector 0..2^N_IN-1 in ascending order onto a device under test and holds each vector for a programmable number of clocks. It samples the DUT output for each vector into a captured truth table and counts the ones. It sits between a combinational exercise block and its bench or top-level, replacing hand-written per-vector stimulus.

## Interface
- `N_IN`, 4: DUT input count; legal 1..8.
- `DWELL`, 1: clocks each vector is held; legal 1..255.
- `EXPECTED`, 0: expected truth table, width 2^N_IN; bit k is the expected output for vector k. Used only with `SWEEPER_COMPARE_EN`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a sweep; sampled in IDLE or DONE.
- `abort` in 1: synchronous sweep cancel.
- `dut_y` in 1: DUT output.
- `vec_out` out N_IN: vector driven to the DUT inputs; MSB maps to the first DUT input.
- `busy` out 1: sweep in progress.
- `done` out 1: one-cycle pulse when the sweep completes.
- `table_out` out 2^N_IN: captured truth table.
- `ones_count` out N_IN+1: number of 1 outputs captured.
- `fail`, `pass` out 1: compare result; present only with the macro.
- `fail_idx` out N_IN: index of the first mismatch; present only with the macro.

## Operation
- FSM states: IDLE, APPLY, DONE.
- IDLE:
  - `start`=1 moves to APPLY.
  - That same edge also sets `vec_out`=0, dwell counter=0, `table_out`=0, `ones_count`=0, `fail`=0 and `fail_idx`=0.
- APPLY:
  - `vec_out` is held for DWELL clocks.
  - On the edge that ends the DWELL-th clock, `table_out[vec_out]`<=`dut_y`, `ones_count`+=`dut_y`, and `vec_out`<=`vec_out`+1.
  - On the last vector (all ones), the FSM goes to DONE instead of wrapping, and `vec_out` returns to 0.
- DONE: lasts exactly one cycle, with `done`=1, then returns to IDLE.
  - `start`=1 during DONE starts a new sweep directly, back to back, with no IDLE cycle.
- `busy`=1 exactly while in APPLY.
- `start` while in APPLY is ignored.
- `abort`=1 in APPLY:
  - The FSM goes to IDLE with `vec_out`=0 and `busy`=0.
  - `done` is not pulsed.
  - `table_out` and `ones_count` keep their partial values.
  - `abort` has priority over sample and advance on the same edge.
- `abort` in IDLE or DONE has no effect. If `abort` and `start` are both 1 in DONE or IDLE, `start` wins.
- `table_out` and `ones_count` hold after DONE until the next accepted `start`.
- Arithmetic:
  - `ones_count` is unsigned and cannot overflow; it reaches at most 2^N_IN.
  - The dwell counter is 8-bit and compares against DWELL-1.

## Timing
- Reset values: state IDLE; `vec_out`, `busy`, `done`, `table_out`, `ones_count`, `fail`, `pass` and `fail_idx` are all 0.
- Reset asserted mid-sweep forces these values immediately, without waiting for a clock edge.
- Edge 0 is the edge that accepts `start`. `busy` rises after edge 0, and vector k is driven from edge k·DWELL to edge (k+1)·DWELL.
- `dut_y` is sampled at edge (k+1)·DWELL. The DUT path must settle within DWELL clocks minus setup.
- `done` is high during the cycle following edge 2^N_IN·DWELL. Defaults give 16 clocks.
- All outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- `SWEEPER_COMPARE_EN` defined:
  - Each captured bit is compared against `EXPECTED[k]`.
  - The first mismatch sets `fail`=1 (sticky until the next `start`) and `fail_idx`=k; later mismatches do not change `fail_idx`.
  - `pass`=1 only in the DONE cycle, and only if `fail`=0.
- Not defined: `fail`, `pass` and `fail_idx` ports, and the compare logic, are absent. `EXPECTED` is ignored.

## Test plan
- Defaults, DUT = XOR of 4 inputs, pulse `start` -> `vec_out` steps 0..15 one per clock, `done` 16 clocks after the start edge, `table_out`=16'h6996, `ones_count`=8.
- DWELL=3, DUT = AND of 4 -> each vector stable 3 clocks, `done` at edge 48, `table_out`=16'h8000, `ones_count`=1; `start` pulsed at `vec_out`=7 is ignored.
- `abort` while `vec_out`=5 with XOR DUT -> next cycle IDLE, `busy`=0, no `done`, `table_out`=16'h0016, `ones_count`=3.
- Async `rst` asserted mid-sweep between edges -> all outputs 0 immediately; after release, `start` gives a full clean sweep.
- `start` held high through DONE -> second sweep begins with no IDLE cycle, `table_out` cleared at that edge, second `done` 16 clocks later.
- With `SWEEPER_COMPARE_EN`, `EXPECTED`=16'h6996, DUT stuck at 0 -> `fail`=1, `fail_idx`=1, `pass`=0 at `done`; with the XOR DUT -> `pass`=1 during the `done` cycle.
